// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: owns the register bank write port and display read port.
// After reset it clears X1..X31 (X28 gets SP_INIT). It then shares the write
// port between core writeback and a debug port, with a starvation guard.
// Debug reads borrow the display read port for one cycle.
module regfile_port_ctrl #(
    parameter logic [63:0] SP_INIT  = 64'd65400,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic        iCoreWrite,
    input  logic [4:0]  iCoreReg,
    input  logic [63:0] iCoreData,
    output logic        oCoreStall,
    output logic        oBusy,
    input  logic        iDbgReq,
    input  logic        iDbgWe,
    input  logic [4:0]  iDbgReg,
    input  logic [63:0] iDbgWData,
    output logic        oDbgAck,
    output logic [63:0] oDbgRData,
    input  logic [4:0]  iDispSel,
    output logic [4:0]  oRfWriteReg,
    output logic [63:0] oRfWriteData,
    output logic        oRfRegWrite,
    output logic [4:0]  oRfDispSel,
    input  logic [63:0] iRfDispData
);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_DRD   = 2'd2;
    localparam logic [1:0] S_FORCE = 2'd3;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [1:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic        ack_q, ack_d;
    logic [63:0] rdata_q, rdata_d;
    logic [4:0]  rd_reg_q, rd_reg_d;

    logic        dbg_wr_req;
    logic        dbg_rd_req;
    logic        dbg_grant_idle;
    logic [3:0]  wait_inc;

    // A request is not re-accepted in the cycle its ack is showing.
    assign dbg_wr_req     = (state_q == S_IDLE) & iDbgReq & iDbgWe & ~ack_q;
    assign dbg_rd_req     = (state_q == S_IDLE) & iDbgReq & ~iDbgWe & ~ack_q;
    assign dbg_grant_idle = dbg_wr_req & ~iCoreWrite;
    assign wait_inc       = wait_q + 4'd1;

    // Status and read-path outputs; reset forces the busy/stall view.
    assign oBusy      = iCLR | (state_q == S_INIT);
    assign oCoreStall = iCLR | (state_q == S_INIT) | (state_q == S_FORCE);
    assign oRfDispSel = (!iCLR && state_q == S_DRD) ? rd_reg_q : iDispSel;
    assign oDbgAck    = ack_q;
    assign oDbgRData  = rdata_q;

    // Write port mux: init clear, core writeback, or debug write.
    always_comb begin
        oRfRegWrite  = 1'b0;
        oRfWriteReg  = iCoreReg;
        oRfWriteData = iCoreData;
        if (!iCLR) begin
            case (state_q)
                S_INIT: begin
                    oRfWriteReg  = idx_q;
                    oRfWriteData = (idx_q == 5'd28) ? SP_INIT : '0;
                    oRfRegWrite  = 1'b1;
                end
                S_IDLE: begin
                    if (dbg_grant_idle) begin
                        oRfWriteReg  = iDbgReg;
                        oRfWriteData = iDbgWData;
                        oRfRegWrite  = (iDbgReg != 5'd0);
                    end else begin
                        oRfRegWrite = iCoreWrite & (iCoreReg != 5'd0);
                    end
                end
                S_DRD: begin
                    oRfRegWrite = iCoreWrite & (iCoreReg != 5'd0);
                end
                default: begin
                    oRfWriteReg  = iDbgReg;
                    oRfWriteData = iDbgWData;
                    oRfRegWrite  = (iDbgReg != 5'd0);
                end
            endcase
        end
    end

    // Next-state: init sequencing, debug arbitration and read capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        rd_reg_d = rd_reg_q;
        case (state_q)
            S_INIT: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (dbg_wr_req) begin
                    if (!iCoreWrite) begin
                        ack_d  = 1'b1;
                        wait_d = '0;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == MAX_WAIT_C) begin
                            state_d = S_FORCE;
                        end
                    end
                end else if (dbg_rd_req) begin
                    rd_reg_d = iDbgReg;
                    state_d  = S_DRD;
                end
            end
            S_DRD: begin
                rdata_d = (rd_reg_q == 5'd0) ? '0 : iRfDispData;
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ack_d   = 1'b1;
                wait_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            state_q  <= S_INIT;
            idx_q    <= 5'd1;
            wait_q   <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            rd_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            rd_reg_q <= rd_reg_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed testbench for regfile_port_ctrl with a behavioural register bank.
module tb_regfile_port_ctrl;

    logic        clk;
    logic        iCLR;
    logic        iCoreWrite;
    logic [4:0]  iCoreReg;
    logic [63:0] iCoreData;
    logic        oCoreStall;
    logic        oBusy;
    logic        iDbgReq;
    logic        iDbgWe;
    logic [4:0]  iDbgReg;
    logic [63:0] iDbgWData;
    logic        oDbgAck;
    logic [63:0] oDbgRData;
    logic [4:0]  iDispSel;
    logic [4:0]  oRfWriteReg;
    logic [63:0] oRfWriteData;
    logic        oRfRegWrite;
    logic [4:0]  oRfDispSel;
    logic [63:0] iRfDispData;

    logic [63:0] bank [32];
    int          nwr;
    int          x0wr;
    int          total;
    int          bad;

    regfile_port_ctrl #(.SP_INIT(64'd65400), .MAX_WAIT(4)) dut (
        .iCLK(clk), .iCLR(iCLR),
        .iCoreWrite(iCoreWrite), .iCoreReg(iCoreReg), .iCoreData(iCoreData),
        .oCoreStall(oCoreStall), .oBusy(oBusy),
        .iDbgReq(iDbgReq), .iDbgWe(iDbgWe), .iDbgReg(iDbgReg), .iDbgWData(iDbgWData),
        .oDbgAck(oDbgAck), .oDbgRData(oDbgRData),
        .iDispSel(iDispSel),
        .oRfWriteReg(oRfWriteReg), .oRfWriteData(oRfWriteData), .oRfRegWrite(oRfRegWrite),
        .oRfDispSel(oRfDispSel), .iRfDispData(iRfDispData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register bank model: write on rising edge, combinational display read.
    always @(posedge clk) begin
        if (oRfRegWrite) begin
            bank[oRfWriteReg] <= oRfWriteData;
            nwr = nwr + 1;
            if (oRfWriteReg == 5'd0) x0wr = x0wr + 1;
        end
    end
    assign iRfDispData = bank[oRfDispSel];

    // Checks the 31 init writes starting at the negedge where iCLR just fell.
    task automatic run_init();
        int          nwr0;
        logic [63:0] exp;
        nwr0 = nwr;
        for (int k = 1; k <= 31; k++) begin
            exp = (k == 28) ? 64'd65400 : 64'd0;
            #1;
            total++;
            if (oRfRegWrite !== 1'b1 || oRfWriteReg !== 5'(k) || oRfWriteData !== exp) begin
                bad++;
                $display("FAIL init_write k=%0d: we=%b reg=%0d data=%0h, want we=1 reg=%0d data=%0h",
                         k, oRfRegWrite, oRfWriteReg, oRfWriteData, k, exp);
            end
            total++;
            if (oBusy !== 1'b1 || oCoreStall !== 1'b1) begin
                bad++;
                $display("FAIL init_busy k=%0d: busy=%b stall=%b, want 1 1", k, oBusy, oCoreStall);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (oBusy !== 1'b0 || oCoreStall !== 1'b0) begin
            bad++;
            $display("FAIL init_done: busy=%b stall=%b, want 0 0", oBusy, oCoreStall);
        end
        total++;
        if (nwr - nwr0 !== 31) begin
            bad++;
            $display("FAIL init_count: writes=%0d, want 31", nwr - nwr0);
        end
        total++;
        if (bank[28] !== 64'd65400 || bank[1] !== 64'd0 || bank[31] !== 64'd0 || bank[0] !== 64'h5A5A) begin
            bad++;
            $display("FAIL init_bank: x28=%0h x1=%0h x31=%0h x0=%0h, want 65400 0 0 5a5a",
                     bank[28], bank[1], bank[31], bank[0]);
        end
    endtask

    task automatic test_reset();
        iCLR = 1'b1;
        iDispSel = 5'd3;
        repeat (2) begin
            @(negedge clk);
            #1;
            total++;
            if (oBusy !== 1'b1 || oCoreStall !== 1'b1 || oRfRegWrite !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctl: busy=%b stall=%b we=%b, want 1 1 0", oBusy, oCoreStall, oRfRegWrite);
            end
            total++;
            if (oDbgAck !== 1'b0 || oDbgRData !== 64'd0 || oRfDispSel !== 5'd3) begin
                bad++;
                $display("FAIL reset_out: ack=%b rdata=%0h disp=%0d, want 0 0 3", oDbgAck, oDbgRData, oRfDispSel);
            end
        end
        iCLR = 1'b0;
        run_init();
    endtask

    task automatic test_dbg_write_idle();
        @(negedge clk);
        iCoreWrite = 1'b0;
        iDbgReq = 1'b1; iDbgWe = 1'b1; iDbgReg = 5'd5; iDbgWData = 64'hDEAD;
        #1;
        total++;
        if (oRfRegWrite !== 1'b1 || oRfWriteReg !== 5'd5 || oRfWriteData !== 64'hDEAD || oDbgAck !== 1'b0) begin
            bad++;
            $display("FAIL dbgw_grant: we=%b reg=%0d data=%0h ack=%b, want 1 5 dead 0",
                     oRfRegWrite, oRfWriteReg, oRfWriteData, oDbgAck);
        end
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b1 || oRfRegWrite !== 1'b0) begin
            bad++;
            $display("FAIL dbgw_ack: ack=%b we=%b, want 1 0", oDbgAck, oRfRegWrite);
        end
        iDbgReq = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b0 || bank[5] !== 64'hDEAD) begin
            bad++;
            $display("FAIL dbgw_done: ack=%b x5=%0h, want 0 dead", oDbgAck, bank[5]);
        end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        iCoreWrite = 1'b1; iCoreReg = 5'd9; iCoreData = 64'hC0;
        iDbgReq = 1'b1; iDbgWe = 1'b1; iDbgReg = 5'd7; iDbgWData = 64'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (oRfRegWrite !== 1'b1 || oRfWriteReg !== 5'd9 || oCoreStall !== 1'b0 || oDbgAck !== 1'b0) begin
                bad++;
                $display("FAIL starve_block i=%0d: we=%b reg=%0d stall=%b ack=%b, want 1 9 0 0",
                         i, oRfRegWrite, oRfWriteReg, oCoreStall, oDbgAck);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (oCoreStall !== 1'b1 || oRfRegWrite !== 1'b1 || oRfWriteReg !== 5'd7 || oRfWriteData !== 64'h1234) begin
            bad++;
            $display("FAIL starve_force: stall=%b we=%b reg=%0d data=%0h, want 1 1 7 1234",
                     oCoreStall, oRfRegWrite, oRfWriteReg, oRfWriteData);
        end
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b1 || oCoreStall !== 1'b0 || oRfWriteReg !== 5'd9) begin
            bad++;
            $display("FAIL starve_ack: ack=%b stall=%b reg=%0d, want 1 0 9", oDbgAck, oCoreStall, oRfWriteReg);
        end
        iDbgReq = 1'b0; iCoreWrite = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (bank[7] !== 64'h1234 || bank[9] !== 64'hC0 || oDbgAck !== 1'b0) begin
            bad++;
            $display("FAIL starve_bank: x7=%0h x9=%0h ack=%b, want 1234 c0 0", bank[7], bank[9], oDbgAck);
        end
    endtask

    task automatic test_dbg_read();
        @(negedge clk);
        iDispSel = 5'd3;
        iDbgReq = 1'b1; iDbgWe = 1'b0; iDbgReg = 5'd28;
        #1;
        total++;
        if (oRfDispSel !== 5'd3) begin
            bad++;
            $display("FAIL dbgr_idle_sel: disp=%0d, want 3", oRfDispSel);
        end
        @(negedge clk);
        iCoreWrite = 1'b1; iCoreReg = 5'd2; iCoreData = 64'h22;
        #1;
        total++;
        if (oRfDispSel !== 5'd28 || oDbgAck !== 1'b0 || oRfRegWrite !== 1'b1 || oCoreStall !== 1'b0) begin
            bad++;
            $display("FAIL dbgr_drd: disp=%0d ack=%b we=%b stall=%b, want 28 0 1 0",
                     oRfDispSel, oDbgAck, oRfRegWrite, oCoreStall);
        end
        @(negedge clk);
        iCoreWrite = 1'b0;
        #1;
        total++;
        if (oDbgAck !== 1'b1 || oDbgRData !== 64'd65400 || oRfDispSel !== 5'd3) begin
            bad++;
            $display("FAIL dbgr_ack: ack=%b rdata=%0d disp=%0d, want 1 65400 3", oDbgAck, oDbgRData, oRfDispSel);
        end
        iDbgReq = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b0 || oDbgRData !== 64'd65400 || bank[2] !== 64'h22) begin
            bad++;
            $display("FAIL dbgr_hold: ack=%b rdata=%0d x2=%0h, want 0 65400 22", oDbgAck, oDbgRData, bank[2]);
        end
    endtask

    task automatic test_x0();
        int x0_before;
        x0_before = x0wr;
        @(negedge clk);
        iDbgReq = 1'b1; iDbgWe = 1'b1; iDbgReg = 5'd0; iDbgWData = 64'hFF;
        #1;
        total++;
        if (oRfRegWrite !== 1'b0) begin
            bad++;
            $display("FAIL x0_dbgw_we: we=%b, want 0", oRfRegWrite);
        end
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b1) begin
            bad++;
            $display("FAIL x0_dbgw_ack: ack=%b, want 1", oDbgAck);
        end
        iDbgReq = 1'b0;
        iCoreWrite = 1'b1; iCoreReg = 5'd0; iCoreData = 64'h77;
        @(negedge clk);
        #1;
        total++;
        if (oRfRegWrite !== 1'b0) begin
            bad++;
            $display("FAIL x0_core_we: we=%b, want 0", oRfRegWrite);
        end
        iCoreWrite = 1'b0;
        iDbgReq = 1'b1; iDbgWe = 1'b0; iDbgReg = 5'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (oDbgAck !== 1'b1 || oDbgRData !== 64'd0) begin
            bad++;
            $display("FAIL x0_read: ack=%b rdata=%0h, want 1 0", oDbgAck, oDbgRData);
        end
        iDbgReq = 1'b0;
        total++;
        if (x0wr !== x0_before || bank[0] !== 64'h5A5A) begin
            bad++;
            $display("FAIL x0_untouched: x0 writes=%0d x0=%0h, want %0d 5a5a", x0wr, bank[0], x0_before);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iCLR = 1'b1;
        @(negedge clk);
        iCLR = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        total++;
        if (oRfWriteReg !== 5'd10 || oBusy !== 1'b1) begin
            bad++;
            $display("FAIL mid_idx10: reg=%0d busy=%b, want 10 1", oRfWriteReg, oBusy);
        end
        iCLR = 1'b1;
        #1;
        total++;
        if (oRfRegWrite !== 1'b0 || oBusy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: we=%b busy=%b, want 0 1", oRfRegWrite, oBusy);
        end
        @(negedge clk);
        iCLR = 1'b0;
        run_init();
    endtask

    initial begin
        total = 0; bad = 0; nwr = 0; x0wr = 0;
        for (int i = 0; i < 32; i++) bank[i] = 64'hAAAA_0000 + 64'(i);
        bank[0] = 64'h5A5A;
        iCLR = 1'b1; iCoreWrite = 1'b0; iCoreReg = '0; iCoreData = '0;
        iDbgReq = 1'b0; iDbgWe = 1'b0; iDbgReg = '0; iDbgWData = '0; iDispSel = 5'd3;
        test_reset();
        test_dbg_write_idle();
        test_starvation();
        test_dbg_read();
        test_x0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
